// File: rtl/operand_entry_seq_if.sv
// Bundle carrying the key/switch inputs and the capture-register outputs of the operand entry sequencer.
interface operand_entry_seq_if;
    logic        key_n;
    logic [9:0]  sw;
    logic        enable;
    logic [1:0]  select;
    logic [31:0] data_out;
    logic [1:0]  byte_idx;
    logic [1:0]  phase;
    logic        busy;

    modport master (
        output key_n, sw,
        input  enable, select, data_out, byte_idx, phase, busy
    );

    modport slave (
        input  key_n, sw,
        output enable, select, data_out, byte_idx, phase, busy
    );
endinterface

// File: rtl/operand_entry_seq.sv
// Debounces KEY0, assembles two 32-bit operands from switch bytes and strobes them,
// then the ALU result, into the downstream capture register.
module operand_entry_seq #(
    parameter int DEBOUNCE = 16,
    parameter int ALU_LAT  = 2
) (
    input logic                clk,
    input logic                reset,
    operand_entry_seq_if.slave bus
);
    localparam logic [1:0] ENTER_A = 2'd0;
    localparam logic [1:0] ENTER_B = 2'd1;
    localparam logic [1:0] WAIT    = 2'd2;
    localparam logic [1:0] SHOWN   = 2'd3;

    localparam int DW = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
    localparam int WW = (ALU_LAT > 1) ? $clog2(ALU_LAT + 1) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE - 1);
    localparam logic [WW-1:0] LAT_LOAD = WW'(ALU_LAT);

    logic          sync1_q, sync2_q;
    logic          deb_q, deb_d;
    logic [DW-1:0] debCnt_q, debCnt_d;
    logic          press;

    logic [1:0]    state_q, state_d;
    logic [31:0]   shift_q, shift_d;
    logic [1:0]    idx_q, idx_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          enable_q, enable_d;
    logic [1:0]    select_q, select_d;
    logic [31:0]   data_q, data_d;
    logic [31:0]   word;
    logic          abort;
    logic          unused_sw8;

    assign abort      = bus.sw[9];
    assign unused_sw8 = bus.sw[8];

    // Key levels are kept raw (1 = released); the count restarts whenever the synced level agrees again.
    always_comb begin
        deb_d    = deb_q;
        debCnt_d = '0;
        if (sync2_q != deb_q) begin
            if (debCnt_q == DEB_LAST) begin
                deb_d = sync2_q;
            end else begin
                debCnt_d = debCnt_q + DW'(1);
            end
        end
    end

    assign press = deb_q & ~deb_d;

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        wait_d   = wait_q;
        enable_d = 1'b0;
        select_d = select_q;
        data_d   = data_q;
        word     = shift_q;
        word[{idx_q, 3'b000} +: 8] = bus.sw[7:0];
        case (state_q)
            ENTER_A, ENTER_B: begin
                if (press && abort) begin
                    state_d = ENTER_A;
                    shift_d = '0;
                    idx_d   = 2'd0;
                end else if (press) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        data_d   = word;
                        shift_d  = '0;
                        enable_d = 1'b1;
                        if (state_q == ENTER_A) begin
                            select_d = 2'b00;
                            state_d  = ENTER_B;
                        end else begin
                            select_d = 2'b01;
                            state_d  = WAIT;
                            wait_d   = LAT_LOAD;
                        end
                    end else begin
                        shift_d = word;
                    end
                end
            end
            WAIT: begin
                if (wait_q == '0) begin
                    enable_d = 1'b1;
                    select_d = 2'b10;
                    state_d  = SHOWN;
                end else begin
                    wait_d = wait_q - WW'(1);
                end
            end
            default: begin
                // Leaving SHOWN consumes the press without entering a byte; abort lands in the same place.
                if (press) begin
                    state_d = ENTER_A;
                    shift_d = '0;
                    idx_d   = 2'd0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            deb_q    <= 1'b1;
            debCnt_q <= '0;
            state_q  <= ENTER_A;
            shift_q  <= '0;
            idx_q    <= 2'd0;
            wait_q   <= '0;
            enable_q <= 1'b0;
            select_q <= 2'b00;
            data_q   <= '0;
        end else begin
            sync1_q  <= bus.key_n;
            sync2_q  <= sync1_q;
            deb_q    <= deb_d;
            debCnt_q <= debCnt_d;
            state_q  <= state_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            wait_q   <= wait_d;
            enable_q <= enable_d;
            select_q <= select_d;
            data_q   <= data_d;
        end
    end

    assign bus.enable   = enable_q;
    assign bus.select   = select_q;
    assign bus.data_out = data_q;
    assign bus.byte_idx = idx_q;
    assign bus.phase    = state_q;
    assign bus.busy     = (state_q == WAIT);
endmodule

// File: tb/tb_operand_entry_seq.sv
// Scoreboard bench: a slow-debounce instance covers entry, bounce, abort and reset; a fast one covers presses during WAIT.
`timescale 1ns/1ps
module tb_operand_entry_seq;
    localparam int LAT1 = 2;
    localparam int LAT2 = 16;

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cycle = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t q1[$];
    exp_t q2[$];
    int   lastB[2];
    logic prevEn[2];

    operand_entry_seq_if bus1 ();
    operand_entry_seq_if bus2 ();

    operand_entry_seq #(.DEBOUNCE(16), .ALU_LAT(LAT1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    operand_entry_seq #(.DEBOUNCE(2),  .ALU_LAT(LAT2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pushExp(input int inst, input logic [1:0] sel, input logic [31:0] d);
        exp_t e;
        e.sel  = sel;
        e.data = d;
        if (inst == 0) q1.push_back(e);
        else q2.push_back(e);
    endtask

    task automatic scoreStrobe(input int inst, input logic en, input logic [1:0] sel,
                               input logic [31:0] d, input int lat);
        exp_t e;
        bit   empty;
        if (prevEn[inst] && en) begin
            checks++;
            errors++;
            $display("[TB] FAIL enableBackToBack dut%0d: enable high two cycles, required single pulse", inst + 1);
        end
        prevEn[inst] = en;
        if (en) begin
            empty = (inst == 0) ? (q1.size() == 0) : (q2.size() == 0);
            if (empty) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedStrobe dut%0d: got select=%0d data=0x%0h, required no strobe",
                         inst + 1, sel, d);
            end else begin
                if (inst == 0) e = q1.pop_front();
                else e = q2.pop_front();
                checkOutput("strobeSelect", sel, e.sel);
                checkOutput("strobeData", d, e.data);
                if (sel == 2'b01) lastB[inst] = cycle;
                if (sel == 2'b10) checkOutput("resultLatency", 32'(cycle - lastB[inst]), 32'(lat + 1));
            end
        end
    endtask

    always @(negedge clk) begin
        scoreStrobe(0, bus1.enable, bus1.select, bus1.data_out, LAT1);
        scoreStrobe(1, bus2.enable, bus2.select, bus2.data_out, LAT2);
    end

    task automatic applyStimulus(input logic [7:0] b, input logic ab);
        bus1.sw    = {ab, 1'b0, b};
        bus1.key_n = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        bus1.key_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        bus1.sw = '0;
    endtask

    task automatic applyStimulusWord(input logic [31:0] w);
        for (int i = 0; i < 4; i++) applyStimulus(w[i*8 +: 8], 1'b0);
    endtask

    task automatic applyStimulusFast(input logic [7:0] b);
        bus2.sw    = {2'b00, b};
        bus2.key_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus2.key_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        logic [31:0] w;
        prevEn[0] = 1'b0;
        prevEn[1] = 1'b0;
        lastB[0]  = 0;
        lastB[1]  = 0;
        bus1.key_n = 1'b1;
        bus1.sw    = '0;
        bus2.key_n = 1'b1;
        bus2.sw    = '0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("resetEnable", bus1.enable, 0);
        checkOutput("resetSelect", bus1.select, 0);
        checkOutput("resetData", bus1.data_out, 0);
        checkOutput("resetByteIdx", bus1.byte_idx, 0);
        checkOutput("resetPhase", bus1.phase, 0);
        checkOutput("resetBusy", bus1.busy, 0);
        checkOutput("resetPhase2", bus2.phase, 0);
        reset = 1'b0;

        // Full A/B entry with result capture
        pushExp(0, 2'b00, 32'h12345678);
        applyStimulus(8'h78, 1'b0);
        checkOutput("byteIdxAfter1", bus1.byte_idx, 1);
        applyStimulus(8'h56, 1'b0);
        applyStimulus(8'h34, 1'b0);
        applyStimulus(8'h12, 1'b0);
        checkOutput("phaseAfterA", bus1.phase, 1);
        checkOutput("byteIdxAfterA", bus1.byte_idx, 0);
        pushExp(0, 2'b01, 32'h00000003);
        pushExp(0, 2'b10, 32'h00000003);
        applyStimulusWord(32'h00000003);
        checkOutput("phaseShown", bus1.phase, 3);
        checkOutput("busyShown", bus1.busy, 0);
        checkOutput("dataHeld", bus1.data_out, 32'h00000003);
        checkOutput("selectHeld", bus1.select, 2'b10);

        // Leave SHOWN; that press enters nothing
        applyStimulus(8'hAA, 1'b0);
        checkOutput("phaseLeaveShown", bus1.phase, 0);
        checkOutput("byteIdxLeaveShown", bus1.byte_idx, 0);

        // Bouncing key yields exactly one press
        pushExp(0, 2'b00, 32'h44332211);
        bus1.sw = {2'b00, 8'h11};
        for (int i = 0; i < 8; i++) begin
            bus1.key_n = ~bus1.key_n;
            repeat (5) @(posedge clk);
            #1;
        end
        bus1.key_n = 1'b0;
        repeat (1000) @(posedge clk);
        #1;
        checkOutput("byteIdxBounceHold", bus1.byte_idx, 1);
        bus1.key_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        checkOutput("byteIdxAfterRelease", bus1.byte_idx, 1);
        applyStimulus(8'h22, 1'b0);
        applyStimulus(8'h33, 1'b0);
        applyStimulus(8'h44, 1'b0);
        checkOutput("phaseAfterBounceA", bus1.phase, 1);

        // Abort part way through B
        applyStimulus(8'h55, 1'b0);
        applyStimulus(8'h66, 1'b0);
        checkOutput("byteIdxBeforeAbort", bus1.byte_idx, 2);
        applyStimulus(8'h00, 1'b1);
        checkOutput("phaseAfterAbort", bus1.phase, 0);
        checkOutput("byteIdxAfterAbort", bus1.byte_idx, 0);
        pushExp(0, 2'b00, 32'h04030201);
        applyStimulusWord(32'h04030201);
        checkOutput("phaseAfterAbortA", bus1.phase, 1);

        // Reset landing on the A strobe cycle
        applyStimulus(8'h00, 1'b1);
        checkOutput("phaseBeforeResetTest", bus1.phase, 0);
        pushExp(0, 2'b00, 32'hDEADBEEF);
        applyStimulus(8'hEF, 1'b0);
        applyStimulus(8'hBE, 1'b0);
        applyStimulus(8'hAD, 1'b0);
        bus1.sw    = {2'b00, 8'hDE};
        bus1.key_n = 1'b0;
        n = 0;
        while (bus1.enable !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("[TB] FAIL strobeTimeout: no A strobe within 100 cycles, required one");
        end
        reset      = 1'b1;
        bus1.key_n = 1'b1;
        bus1.sw    = '0;
        @(posedge clk);
        #1;
        checkOutput("rstEnable", bus1.enable, 0);
        checkOutput("rstData", bus1.data_out, 0);
        checkOutput("rstPhase", bus1.phase, 0);
        checkOutput("rstByteIdx", bus1.byte_idx, 0);
        reset = 1'b0;
        w = 32'hCAFEF00D;
        pushExp(0, 2'b00, w);
        for (int i = 0; i < 3; i++) applyStimulus(w[i*8 +: 8], 1'b0);
        checkOutput("byteIdxAfterReset3", bus1.byte_idx, 3);
        applyStimulus(w[31:24], 1'b0);
        checkOutput("phaseAfterResetA", bus1.phase, 1);

        // Presses during WAIT on the fast instance
        pushExp(1, 2'b00, 32'h0A0B0C0D);
        pushExp(1, 2'b01, 32'h00000007);
        pushExp(1, 2'b10, 32'h00000007);
        w = 32'h0A0B0C0D;
        for (int i = 0; i < 4; i++) applyStimulusFast(w[i*8 +: 8]);
        applyStimulusFast(8'h07);
        applyStimulusFast(8'h00);
        applyStimulusFast(8'h00);
        applyStimulusFast(8'h00);
        for (int i = 0; i < 3; i++) applyStimulusFast(8'hFF);
        checkOutput("phaseInWait", bus2.phase, 2);
        checkOutput("busyInWait", bus2.busy, 1);
        repeat (6) @(posedge clk);
        #1;
        checkOutput("phaseAfterWait", bus2.phase, 3);
        checkOutput("byteIdxAfterWait", bus2.byte_idx, 0);
        checkOutput("busyAfterWait", bus2.busy, 0);

        repeat (10) @(posedge clk);
        #1;
        checkOutput("pendingStrobes1", q1.size(), 0);
        checkOutput("pendingStrobes2", q2.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
